// File: rtl/dma_stream_fifo_if.sv
// dma_stream_fifo_if: valid/ready producer and consumer handshake bundle for dma_stream_fifo
interface dma_stream_fifo_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/dma_stream_fifo.sv
// dma_stream_fifo: valid/ready FWFT FIFO with thresholds, flush, high-water mark; optional DMA_STREAM_FIFO_BYPASS_EN empty bypass
module dma_stream_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    dma_stream_fifo_if.slave s,
    input  logic [LVL_W-1:0] af_thresh_i,
    input  logic [LVL_W-1:0] ae_thresh_i,
    output logic [LVL_W-1:0] level_o,
    output logic [LVL_W-1:0] max_level_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  count, max_q, cnt_nx;
    logic              byp, pass, wr, rd;
    // status flags, handshakes and the next occupancy; a bypassed beat touches no state
    always_comb begin
        level_o        = count;
        max_level_o    = max_q;
        empty_o        = (count == '0);
        full_o         = (count == LVL_W'(DEPTH));
        almost_full_o  = (count >= af_thresh_i);
        almost_empty_o = (count <= ae_thresh_i);
        s.in_ready     = !full_o && !flush_i;
`ifdef DMA_STREAM_FIFO_BYPASS_EN
        byp            = empty_o && !flush_i;
`else
        byp            = 1'b0;
`endif
        s.out_valid    = byp ? s.in_valid : (!empty_o && !flush_i);
        s.out_data     = byp ? s.in_data : mem[rd_ptr];
        pass           = byp && s.in_valid && s.out_ready;
        wr             = s.in_valid && s.in_ready && !pass;
        rd             = s.out_valid && s.out_ready && !pass;
        cnt_nx         = count + LVL_W'(wr) - LVL_W'(rd);
    end
    // pointers, occupancy and high-water mark; flush outranks any handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            max_q  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            max_q  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(rd);
            count  <= cnt_nx;
            if (cnt_nx > max_q) max_q <= cnt_nx;
        end
    end
    // storage is unreset; only the addressed entry is written on an accepted beat
    always_ff @(posedge clk_i) begin
        if (wr) mem[wr_ptr] <= s.in_data;
    end
endmodule

// File: tb/tb_dma_stream_fifo.sv
// tb_dma_stream_fifo: directed stimulus with a queue scoreboard checked by an independent output monitor
module tb_dma_stream_fifo;
`ifdef DMA_STREAM_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] af = '0, ae = '0;
    logic [4:0] level, max_level;
    logic       full, empty, af_o, ae_o;
    int         n_cmp = 0, n_err = 0, n_pop = 0;
    logic [31:0] exp_q [$];
    dma_stream_fifo_if #(.DATA_W(32)) bus ();
    dma_stream_fifo #(.DATA_W(32), .DEPTH(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .s(bus),
        .af_thresh_i(af), .ae_thresh_i(ae), .level_o(level), .max_level_o(max_level),
        .full_o(full), .empty_o(empty), .almost_full_o(af_o), .almost_empty_o(ae_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // monitor: record accepted input beats, compare every consumed output beat in order
    always @(negedge clk) begin
        if (!rst_n || flush) exp_q.delete();
        else begin
            if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
            if (bus.out_valid && bus.out_ready) begin
                n_pop++;
                if (exp_q.size() == 0) chk("pop_unexpected", bus.out_data, 32'hx);
                else chk("pop_data", bus.out_data, exp_q.pop_front());
            end
        end
    end
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst_level", level, 0);
        chk("rst_max", max_level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_ae", ae_o, 1);
        chk("rst_af_zero_thresh", af_o, 1);
        af = 5'd12;
        ae = 5'd3;
        #1;
        chk("rst_af_12", af_o, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("fill_level", level, i);
            chk("fill_ae", ae_o, i <= 3);
            chk("fill_af", af_o, i >= 12);
            bus.in_valid = 1'b1;
            bus.in_data = i;
            step();
        end
        bus.in_valid = 1'b0;
        chk("full_level", level, 16);
        chk("full_flag", full, 1);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_max", max_level, 16);
        chk("full_ae", ae_o, 0);
        chk("full_af", af_o, 1);
        chk("full_head", bus.out_data, 0);
        bus.out_ready = 1'b1;
        step();
        chk("pop_frees_ready", bus.in_ready, 1);
        repeat (7) step();
        bus.out_ready = 1'b0;
        chk("mid_level", level, 8);
        chk("mid_af_12", af_o, 0);
        af = 5'd5;
        #1;
        chk("mid_af_5", af_o, 1);
        af = 5'd12;
        bus.out_ready = 1'b1;
        repeat (8) step();
        bus.out_ready = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_level", level, 0);
        chk("drain_pops", n_pop, 16);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 32'hA5A5A5A5;
        #1;
        chk("empty_push_valid", bus.out_valid, BYP);
`ifdef DMA_STREAM_FIFO_BYPASS_EN
        chk("byp_data", bus.out_data, 32'hA5A5A5A5);
`endif
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("empty_push_level", level, BYP ? 0 : 1);
        chk("empty_push_valid_next", bus.out_valid, !BYP);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("empty_push_drained", level, 0);
        bus.in_valid = 1'b1;
        bus.in_data = 32'h5A5A5A5A;
        #1;
        chk("stall_push_valid", bus.out_valid, BYP);
        step();
        bus.in_valid = 1'b0;
        chk("stall_push_level", level, 1);
        chk("stall_push_data", bus.out_data, 32'h5A5A5A5A);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("stall_push_drained", level, 0);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 32'h100 + i;
            step();
        end
        chk("wrap_preload", level, 8);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in_data = 32'h200 + i;
            step();
            chk("wrap_level", level, 8);
        end
        bus.in_valid = 1'b0;
        repeat (8) step();
        bus.out_ready = 1'b0;
        chk("wrap_empty", empty, 1);
        chk("wrap_max", max_level, 16);
        chk("wrap_pops", n_pop, 66);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 32'h300 + i;
            step();
        end
        chk("flush_pre_level", level, 10);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_data = 32'hBAD;
        #1;
        chk("flush_in_ready", bus.in_ready, 0);
        chk("flush_out_valid", bus.out_valid, 0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_max", max_level, 0);
        chk("flush_empty", empty, 1);
        bus.in_valid = 1'b1;
        bus.in_data = 32'h400;
        step();
        bus.in_valid = 1'b0;
        chk("post_flush_max", max_level, 1);
        chk("post_flush_data", bus.out_data, 32'h400);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 32'h500 + i;
            step();
        end
        bus.in_valid = 1'b0;
        chk("prereset_level", level, 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_max", max_level, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_ae", ae_o, 1);
        chk("arst_af", af_o, 0);
        step();
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 32'h600;
        step();
        bus.in_valid = 1'b0;
        chk("post_rst_level", level, 1);
        chk("post_rst_data", bus.out_data, 32'h600);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        step();
        chk("final_level", level, 0);
        chk("final_pops", n_pop, 68);
        chk("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
